ws281x_frame_driver: RTL

// - Serialises a frame of pixels from a synchronous-read pixel RAM onto a single-wire WS281x LED chain.
// - Successor to the fixed 24-bit, 512-pixel, free-running driver. Adds:
//   - parametrised timing, pixel width (RGB/RGBW) and address depth;
//   - runtime frame length;
//   - START/BUSY/FRAME_DONE handshake with one-shot or continuous mode;
//   - prefetch of the next pixel, so the bitstream is gapless for any RAM latency.
// - Sits between the frame-buffer BlockRAM and the LED data pin.

---
 rtl/ws281x_pkg.sv | 22 ++
 rtl/ws281x_bit_encoder.sv | 42 ++++
 rtl/ws281x_frame_driver.sv | 128 ++++++++++++
 3 files changed

// File: rtl/ws281x_pkg.sv
// Shared state encoding, 20 MHz timing defaults and pixel-width choices
// for the WS281x frame driver.
package ws281x_pkg;
  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_LOAD  = 2'd1;
  localparam state_t ST_SEND  = 2'd2;
  localparam state_t ST_LATCH = 2'd3;

  localparam int DEF_T_BIT   = 25;
  localparam int DEF_T0H     = 8;
  localparam int DEF_T1H     = 16;
  localparam int DEF_T_LATCH = 1000;

  localparam int PIX_GRB  = 24;
  localparam int PIX_GRBW = 32;

  function automatic bit pix_bits_ok(input int b);
    return (b == PIX_GRB) || (b == PIX_GRBW);
  endfunction
endpackage

// File: rtl/ws281x_bit_encoder.sv
// Bit-period counter and registered DOUT. i_en/i_bit describe the cycle that
// starts at the coming edge, so DOUT is a clean flop output with no lag.
module ws281x_bit_encoder
  import ws281x_pkg::*;
#(
  parameter int T_BIT = DEF_T_BIT,
  parameter int T0H   = DEF_T0H,
  parameter int T1H   = DEF_T1H
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_en,
  input  logic i_bit,
  output logic o_bit_end,
  output logic o_dout
);
  localparam int CW = $clog2(T_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(T_BIT - 1);
  localparam logic [CW-1:0] H0 = CW'(T0H);
  localparam logic [CW-1:0] H1 = CW'(T1H);

  logic          r_act;
  logic [CW-1:0] r_cnt;
  logic          r_dout;
  logic [CW-1:0] w_cnt_nxt;

  assign o_bit_end = r_act && (r_cnt == CNT_LAST);
  assign w_cnt_nxt = (!r_act || o_bit_end) ? '0 : r_cnt + CW'(1);
  assign o_dout    = r_dout;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_act  <= 1'b0;
      r_cnt  <= '0;
      r_dout <= 1'b0;
    end else begin
      r_act  <= i_en;
      r_cnt  <= i_en ? w_cnt_nxt : '0;
      r_dout <= i_en && (w_cnt_nxt < (i_bit ? H1 : H0));
    end
  end
endmodule

// File: rtl/ws281x_frame_driver.sv
// Streams LAST_ADDR+1 pixels from a synchronous-read RAM onto a WS281x chain,
// prefetching the next pixel so bit periods stay back-to-back.
module ws281x_frame_driver
  import ws281x_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int PIX_BITS    = PIX_GRB,
  parameter int RAM_LATENCY = 1,
  parameter int T_BIT       = DEF_T_BIT,
  parameter int T0H         = DEF_T0H,
  parameter int T1H         = DEF_T1H,
  parameter int T_LATCH     = DEF_T_LATCH
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic                i_continuous,
  input  logic [ADDR_W-1:0]   i_last_addr,
  output logic [ADDR_W-1:0]   o_ram_addr,
  input  logic [PIX_BITS-1:0] i_ram_data,
  output logic                o_busy,
  output logic                o_frame_done,
  output logic                o_dout
);
  if (!(T0H < T1H && T1H < T_BIT)) begin : g_bad_timing
    $error("ws281x_frame_driver: need T0H < T1H < T_BIT");
  end
  if (!pix_bits_ok(PIX_BITS)) begin : g_bad_pix
    $error("ws281x_frame_driver: PIX_BITS must be 24 or 32");
  end
  if (RAM_LATENCY < 1 || RAM_LATENCY > 4) begin : g_bad_lat
    $error("ws281x_frame_driver: RAM_LATENCY must be 1..4");
  end

  localparam int LW = $clog2(T_LATCH);
  localparam int BW = $clog2(PIX_BITS);
  localparam logic [LW-1:0] LATCH_END = LW'(T_LATCH - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(PIX_BITS - 1);
  localparam logic [2:0]    LOAD_END  = 3'(RAM_LATENCY);

  state_t              r_state, w_state_nxt;
  logic [LW-1:0]       r_lat_cnt;
  logic [2:0]          r_load_cnt;
  logic [ADDR_W-1:0]   r_last, r_pix, r_ram_addr, w_new_idx;
  logic [PIX_BITS-1:0] r_shift, r_next, w_shift_nxt;
  logic [BW-1:0]       r_bidx;
  logic [RAM_LATENCY:0] r_pf_vld;
  logic r_had_frame, r_frame_done;
  logic w_bit_end, w_send_bit_end, w_load_done, w_pix_end, w_frame_end;
  logic w_lat_end, w_accept, w_restart, w_new_pix, w_prefetch;

  assign w_send_bit_end = (r_state == ST_SEND) && w_bit_end;
  assign w_load_done    = (r_state == ST_LOAD) && (r_load_cnt == LOAD_END);
  assign w_pix_end      = w_send_bit_end && (r_bidx == BIT_LAST);
  assign w_frame_end    = w_pix_end && (r_pix == r_last);
  assign w_lat_end      = (r_state == ST_LATCH) && (r_lat_cnt == LATCH_END);
  assign w_accept       = (r_state == ST_IDLE) && i_start;
  assign w_restart      = w_lat_end && r_had_frame && i_continuous;
  // Index of the pixel that begins at this edge; the one after it is fetched now.
  assign w_new_pix      = w_load_done || (w_pix_end && !w_frame_end);
  assign w_new_idx      = w_load_done ? '0 : r_pix + ADDR_W'(1);
  assign w_prefetch     = w_new_pix && (w_new_idx != r_last);

  always_comb begin
    w_shift_nxt = r_shift;
    if (w_load_done)         w_shift_nxt = i_ram_data;
    else if (w_pix_end)      w_shift_nxt = r_next;
    else if (w_send_bit_end) w_shift_nxt = {r_shift[PIX_BITS-2:0], 1'b0};
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (i_start)     w_state_nxt = ST_LOAD;
      ST_LOAD: if (w_load_done) w_state_nxt = ST_SEND;
      ST_SEND: if (w_frame_end) w_state_nxt = ST_LATCH;
      default: if (w_lat_end)   w_state_nxt = w_restart ? ST_LOAD : ST_IDLE;
    endcase
  end

  ws281x_bit_encoder #(.T_BIT(T_BIT), .T0H(T0H), .T1H(T1H)) u_enc (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_en      (w_state_nxt == ST_SEND),
    .i_bit     (w_shift_nxt[PIX_BITS-1]),
    .o_bit_end (w_bit_end),
    .o_dout    (o_dout)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= ST_LATCH;
      r_lat_cnt    <= '0;
      r_load_cnt   <= '0;
      r_last       <= '0;
      r_pix        <= '0;
      r_ram_addr   <= '0;
      r_shift      <= '0;
      r_next       <= '0;
      r_bidx       <= '0;
      r_pf_vld     <= '0;
      r_had_frame  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_shift      <= w_shift_nxt;
      r_pf_vld     <= {r_pf_vld[RAM_LATENCY-1:0], w_prefetch};
      r_frame_done <= w_lat_end && r_had_frame;
      r_lat_cnt    <= (r_state == ST_LATCH) ? r_lat_cnt + LW'(1) : '0;
      r_load_cnt   <= (r_state == ST_LOAD) ? r_load_cnt + 3'd1 : '0;
      if (r_pf_vld[RAM_LATENCY]) r_next <= i_ram_data;
      if (w_accept || w_restart) begin
        r_last     <= i_last_addr;
        r_pix      <= '0;
        r_ram_addr <= '0;
      end
      if (w_new_pix && !w_load_done) r_pix <= w_new_idx;
      if (w_prefetch) r_ram_addr <= w_new_idx + ADDR_W'(1);
      if (w_send_bit_end) r_bidx <= w_pix_end ? '0 : r_bidx + BW'(1);
      if (w_frame_end)    r_had_frame <= 1'b1;
      else if (w_lat_end) r_had_frame <= 1'b0;
    end
  end

  assign o_ram_addr   = r_ram_addr;
  assign o_busy       = (r_state != ST_IDLE);
  assign o_frame_done = r_frame_done;
endmodule
